// File: rtl/idli_sqi_m.sv
// Quad-SPI (SQI) SRAM master: nibble-serial 16b address in, SQI read/write frame out.
// Define IDLI_SQI_WRITE_EN to build write support; otherwise every request is a read.
module idli_sqi_m (
  input  logic       i_sqi_gck,
  input  logic       i_sqi_rst,
  input  logic       i_sqi_req,
  input  logic       i_sqi_wr,
  input  logic [3:0] i_sqi_addr,
  input  logic [3:0] i_sqi_wdata,
  output logic       o_sqi_wdata_rdy,
  output logic [3:0] o_sqi_rdata,
  output logic       o_sqi_rdata_vld,
  output logic       o_sqi_busy,
  output logic       o_sqi_done,
  output logic       o_sqi_cs_n,
  output logic       o_sqi_sck_en,
  output logic [3:0] o_sqi_sio,
  output logic       o_sqi_sio_oe,
  input  logic [3:0] i_sqi_sio
);

  typedef enum logic [2:0] {
    StIdle, StCmd, StAddrHi, StAddr, StDummy, StRdata, StWdata, StEnd
  } state_e;

  state_e      state_q;
  logic [3:0]  k_q;
  logic        wr_q;
  logic [15:0] addr_buf_q;
  logic        wr_req;

`ifdef IDLI_SQI_WRITE_EN
  assign wr_req = i_sqi_wr;
`else
  logic unused_wr;
  assign wr_req    = 1'b0;
  assign unused_wr = ^{i_sqi_wr, i_sqi_wdata};
`endif

  // k_q holds the current cycle index k; each branch registers the outputs for k+1.
  always_ff @(posedge i_sqi_gck) begin
    if (i_sqi_rst) begin
      state_q         <= StIdle;
      k_q             <= 4'd0;
      wr_q            <= 1'b0;
      o_sqi_wdata_rdy <= 1'b0;
      o_sqi_rdata     <= 4'h0;
      o_sqi_rdata_vld <= 1'b0;
      o_sqi_busy      <= 1'b0;
      o_sqi_done      <= 1'b0;
      o_sqi_cs_n      <= 1'b1;
      o_sqi_sck_en    <= 1'b0;
      o_sqi_sio       <= 4'h0;
      o_sqi_sio_oe    <= 1'b0;
    end else begin
      o_sqi_rdata_vld <= 1'b0;
      o_sqi_done      <= 1'b0;
      o_sqi_wdata_rdy <= 1'b0;
      if (state_q != StIdle) k_q <= k_q + 4'd1;

      // Address nibbles 1..3 arrive while the command and high address byte go out
      if ((state_q == StCmd || state_q == StAddrHi) && k_q <= 4'd3) begin
        case (k_q[1:0])
          2'd1:    addr_buf_q[7:4]   <= i_sqi_addr;
          2'd2:    addr_buf_q[11:8]  <= i_sqi_addr;
          2'd3:    addr_buf_q[15:12] <= i_sqi_addr;
          default: ;
        endcase
      end

      case (state_q)
        StIdle: begin
          if (i_sqi_req) begin
            state_q         <= StCmd;
            k_q             <= 4'd1;
            wr_q            <= wr_req;
            addr_buf_q[3:0] <= i_sqi_addr;
            o_sqi_busy      <= 1'b1;
            o_sqi_cs_n      <= 1'b0;
            o_sqi_sck_en    <= 1'b1;
            o_sqi_sio_oe    <= 1'b1;
            o_sqi_sio       <= 4'h0;
          end
        end
        StCmd: begin
          if (k_q == 4'd1) begin
            o_sqi_sio <= wr_q ? 4'h2 : 4'h3;
          end else begin
            state_q   <= StAddrHi;
            o_sqi_sio <= 4'h0;
          end
        end
        StAddrHi: begin
          if (k_q == 4'd3) begin
            o_sqi_sio <= 4'h0;
          end else begin
            state_q   <= StAddr;
            o_sqi_sio <= addr_buf_q[15:12];
          end
        end
        StAddr: begin
          case (k_q)
            4'd5: o_sqi_sio <= addr_buf_q[11:8];
            4'd6: o_sqi_sio <= addr_buf_q[7:4];
            4'd7: begin
              o_sqi_sio       <= addr_buf_q[3:0];
              o_sqi_wdata_rdy <= wr_q;
            end
            default: begin
`ifdef IDLI_SQI_WRITE_EN
              if (wr_q) begin
                state_q         <= StWdata;
                o_sqi_sio       <= i_sqi_wdata;
                o_sqi_wdata_rdy <= 1'b1;
              end else
`endif
              begin
                state_q      <= StDummy;
                o_sqi_sio_oe <= 1'b0;
                o_sqi_sio    <= 4'h0;
              end
            end
          endcase
        end
        StDummy: begin
          if (k_q == 4'd10) state_q <= StRdata;
        end
        StRdata: begin
          o_sqi_rdata     <= i_sqi_sio;
          o_sqi_rdata_vld <= 1'b1;
          if (k_q == 4'd14) begin
            state_q      <= StEnd;
            o_sqi_sck_en <= 1'b0;
            o_sqi_cs_n   <= 1'b1;
            o_sqi_done   <= 1'b1;
          end
        end
`ifdef IDLI_SQI_WRITE_EN
        StWdata: begin
          if (k_q <= 4'd11) begin
            o_sqi_sio       <= i_sqi_wdata;
            o_sqi_wdata_rdy <= (k_q <= 4'd10);
          end else begin
            state_q      <= StEnd;
            o_sqi_sck_en <= 1'b0;
            o_sqi_cs_n   <= 1'b1;
            o_sqi_sio_oe <= 1'b0;
            o_sqi_sio    <= 4'h0;
            o_sqi_done   <= 1'b1;
          end
        end
`endif
        StEnd: begin
          state_q    <= StIdle;
          k_q        <= 4'd0;
          o_sqi_busy <= 1'b0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_idli_sqi_m.sv
// Directed bench for idli_sqi_m: SIO frame and read data checked through scoreboard queues.
module tb_idli_sqi_m;

`ifdef IDLI_SQI_WRITE_EN
  localparam bit WrEn = 1'b1;
`else
  localparam bit WrEn = 1'b0;
`endif

  logic       clk, rst, req, wr;
  logic [3:0] addr, wdata, sio_in;
  logic       wdata_rdy, rdata_vld, busy, done, cs_n, sck_en, sio_oe;
  logic [3:0] rdata, sio;

  int n_cmp = 0;
  int n_err = 0;
  bit mon_en = 1'b0;
  logic [3:0] exp_sio[$];
  logic [3:0] exp_rd[$];

  idli_sqi_m dut (
    .i_sqi_gck      (clk),
    .i_sqi_rst      (rst),
    .i_sqi_req      (req),
    .i_sqi_wr       (wr),
    .i_sqi_addr     (addr),
    .i_sqi_wdata    (wdata),
    .o_sqi_wdata_rdy(wdata_rdy),
    .o_sqi_rdata    (rdata),
    .o_sqi_rdata_vld(rdata_vld),
    .o_sqi_busy     (busy),
    .o_sqi_done     (done),
    .o_sqi_cs_n     (cs_n),
    .o_sqi_sck_en   (sck_en),
    .o_sqi_sio      (sio),
    .o_sqi_sio_oe   (sio_oe),
    .i_sqi_sio      (sio_in)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Scoreboard side: pop whenever the DUT drives SIO or presents read data.
  always @(negedge clk) begin
    if (mon_en) begin
      if (sio_oe === 1'b1 && cs_n === 1'b0) begin
        if (exp_sio.size() == 0) check("sio_unexpected", {15'd0, sio_oe}, 16'd0);
        else check("sio_nibble", {12'd0, sio}, {12'd0, exp_sio.pop_front()});
      end
      if (sio_oe !== 1'b1) check("sio_zero_when_oe0", {12'd0, sio}, 16'd0);
      if (cs_n === 1'b1) check("oe_zero_when_cs1", {15'd0, sio_oe}, 16'd0);
      if (rdata_vld === 1'b1) begin
        if (exp_rd.size() == 0) check("rdata_unexpected", {15'd0, rdata_vld}, 16'd0);
        else check("rdata_nibble", {12'd0, rdata}, {12'd0, exp_rd.pop_front()});
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_cs_n"}, {15'd0, cs_n}, 16'd1);
    check({tag, "_sck_en"}, {15'd0, sck_en}, 16'd0);
    check({tag, "_sio_oe"}, {15'd0, sio_oe}, 16'd0);
    check({tag, "_busy"}, {15'd0, busy}, 16'd0);
    check({tag, "_done"}, {15'd0, done}, 16'd0);
    check({tag, "_rdata_vld"}, {15'd0, rdata_vld}, 16'd0);
    check({tag, "_wdata_rdy"}, {15'd0, wdata_rdy}, 16'd0);
  endtask

  // One frame starting at the current cycle (k=0). abort_k>=0 pulses reset at that k.
  task automatic frame(input logic [15:0] a, input logic wr_in, input logic [15:0] d,
                       input int abort_k, input bit extra_reqs);
    bit w;
    int last;
    w    = wr_in & WrEn;
    last = w ? 13 : 15;
    exp_sio.push_back(4'h0);
    exp_sio.push_back(w ? 4'h2 : 4'h3);
    exp_sio.push_back(4'h0);
    exp_sio.push_back(4'h0);
    for (int i = 3; i >= 0; i--) exp_sio.push_back(a[i*4 +: 4]);
    for (int i = 3; i >= 0; i--) begin
      if (w) exp_sio.push_back(d[i*4 +: 4]);
      else exp_rd.push_back(d[i*4 +: 4]);
    end
    for (int k = 0; k <= last; k++) begin
      req    = (k == 0) || (extra_reqs && (k == 5 || k == 10));
      wr     = wr_in;
      addr   = (k <= 3) ? a[k*4 +: 4] : 4'($urandom);
      wdata  = (k >= 8 && k <= 11) ? d[(11-k)*4 +: 4] : 4'($urandom);
      sio_in = (!w && k >= 11 && k <= 14) ? d[(14-k)*4 +: 4] : 4'($urandom);
      rst    = (k == abort_k);
      @(negedge clk);
      if (abort_k >= 0 && k > abort_k) begin
        check_reset_outputs("abort");
        if (k == abort_k + 1) begin
          check("abort_rdata", {12'd0, rdata}, 16'd0);
          exp_sio.delete();
          exp_rd.delete();
        end
      end else begin
        check("cs_n", {15'd0, cs_n}, {15'd0, !(k >= 1 && k < last)});
        check("sck_en", {15'd0, sck_en}, {15'd0, (k >= 1 && k < last)});
        check("busy", {15'd0, busy}, {15'd0, (k >= 1)});
        check("done", {15'd0, done}, {15'd0, (k == last)});
        check("wdata_rdy", {15'd0, wdata_rdy}, {15'd0, (w && k >= 8 && k <= 11)});
        check("rdata_vld", {15'd0, rdata_vld}, {15'd0, (!w && k >= 12 && k <= 15)});
      end
      @(posedge clk);
      #1;
    end
    req = 1'b0;
    rst = 1'b0;
  endtask

  initial begin
    rst    = 1'b1;
    req    = 1'b0;
    wr     = 1'b0;
    addr   = 4'h0;
    wdata  = 4'h0;
    sio_in = 4'h0;
    repeat (2) begin
      @(posedge clk);
      #1 req = 1'b1;
      @(negedge clk);
      check_reset_outputs("reset");
      check("reset_sio", {12'd0, sio}, 16'd0);
      check("reset_rdata", {12'd0, rdata}, 16'd0);
    end
    @(posedge clk);
    #1;
    rst    = 1'b0;
    req    = 1'b0;
    mon_en = 1'b1;

    frame(16'hA5C3, 1'b0, 16'h1234, -1, 1'b0);
    frame(16'h1234, 1'b1, 16'h9876, -1, 1'b0);
    // Ignored requests mid-read, then a back-to-back request at k=16.
    frame(16'h5A3C, 1'b0, 16'hBEEF, -1, 1'b1);
    frame(16'h0F0F, 1'b0, 16'hCAFE, -1, 1'b0);
    frame(16'hA5C3, 1'b0, 16'h1234, 7, 1'b0);
    frame(16'hFFFF, 1'b1, 16'h0A50, -1, 1'b0);
    frame(16'h8001, 1'b0, 16'h7E81, -1, 1'b0);

    repeat (2) @(negedge clk);
    check("sio_queue_empty", 16'(exp_sio.size()), 16'd0);
    check("rd_queue_empty", 16'(exp_rd.size()), 16'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
